fp_mult_rr_sched: RTL and testbench
===================================

# fp_mult_rr_sched

Round-robin scheduler that shares one pipelined signed fixed-point multiplier (go/done protocol, 4-cycle go-to-done latency) among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the multiplier's `go` level correctly, including the mandatory one-cycle `go`-low gap between operations. It returns each truncated product with the requester ID, and flags a sticky error if `done` fails to arrive on time. It sits between the Calyx-generated control groups and a single multiplier instance.

## Interface
- `WIDTH`, 4: operand/result width; passed through to the multiplier unchanged.
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ID_W`, 3: width of `resp_id`; must satisfy `2**ID_W >= NUM_REQ`.
- `LATENCY`, 4: number of BUSY cycles up to and including the cycle in which `mult_done` must be seen.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; also drives the multiplier's `reset`.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_left`  in  `NUM_REQ*WIDTH`  packed left operands; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_right`  in  `NUM_REQ*WIDTH`  packed right operands; same packing.
- `req_ready`  out  `NUM_REQ`  one-hot grant; handshake occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  1  one-cycle pulse; result available.
- `resp_id`  out  `ID_W`  requester index of the result.
- `resp_data`  out  `WIDTH`  product (registered copy of `mult_out`).
- `mult_go`  out  1  multiplier go.
- `mult_left`  out  `WIDTH`  latched operand to the multiplier.
- `mult_right`  out  `WIDTH`  latched operand to the multiplier.
- `mult_out`  in  `WIDTH`  multiplier result.
- `mult_done`  in  1  multiplier done.
- `err`  out  1  sticky timeout flag; cleared only by `reset`.

## Operation
- **States:** IDLE, BUSY, GAP. `mult_go` = (state == BUSY), driven registered from state.
- **Arbitration:** happens in IDLE and GAP only.
  - If any `req_valid` is high, pick the first requester searching upward (with wrap) from `last_grant+1`.
  - Assert `req_ready` for that requester combinationally, in the same cycle.
  - Latch its operands into `mult_left`/`mult_right`, record the ID, update `last_grant`, and go to BUSY.
  - If no request is pending, go (or stay) IDLE.
- **`req_ready`:** always zero in BUSY. At most one bit is set in any cycle.
- **BUSY:**
  - Operands are held stable and a BUSY-cycle counter increments.
  - When `mult_done` = 1: register `mult_out` into `resp_data`, set `resp_id` to the latched ID, and go to GAP.
  - If the counter reaches `LATENCY` without `mult_done`: set `err`, go to GAP, and raise no `resp_valid`.
- **GAP:**
  - `mult_go` = 0 for exactly one cycle. This clears the multiplier's done pipeline; an op must never be re-issued without this cycle.
  - `resp_valid` = 1 in this cycle, unless the op timed out.
  - Arbitration runs in the same cycle, so back-to-back issue is allowed.
- **`mult_done` outside BUSY:** ignored.
- **Arithmetic:** none inside the scheduler. `resp_data` is the multiplier's low `WIDTH` bits of the signed product, wrapping on overflow.
- **Reset (including mid-operation):**
  - State → IDLE, `last_grant` → `NUM_REQ-1` (requester 0 wins first).
  - `mult_go`, `req_ready`, `resp_valid`, `err` → 0.
  - `mult_left`, `mult_right`, `resp_data`, `resp_id` → 0.
  - Any in-flight op is dropped with no response.
- **Requester rule:** a requester must hold `req_valid` and its operands stable until its handshake.

## Timing
- **Handshake cycle T** (IDLE or GAP):
  - BUSY during T+1..T+4; `mult_go` is high in T+1..T+4.
  - `mult_done` is expected in T+4.
  - GAP in T+5, with `resp_valid` = 1 and `resp_data` valid in T+5.
- **Throughput:** one op per 5 cycles with continuous requests. The next handshake may occur at T+5.
- **Response hold:** `resp_data` and `resp_id` hold their values until the next capture.
- **Timeout:** `err` is set at the edge ending the `LATENCY`-th BUSY cycle and is visible from the next cycle.
- **Simultaneous events in GAP:** response out plus new grant in the same cycle. Both are legal and required.

## Test plan
- **Single op:** reset, then requester 0 sends 3 × 2.
  - `req_ready[0]` is high in cycle T.
  - `mult_go` is high T+1..T+4.
  - `resp_valid` is high in T+5 with `resp_data` = 4'h6, `resp_id` = 0.
- **Signed wrap:** send (−2) × 3, then 7 × 7, then (−8) × (−1).
  - `resp_data` = 4'hA, then 4'h1, then 4'h8.
- **Fairness:** both requesters hold `req_valid` continuously.
  - Grants alternate 0, 1, 0, 1 with handshakes 5 cycles apart.
  - `mult_go` is low in every GAP cycle.
- **Back-to-back:** requester 1 is asserted during requester 0's BUSY.
  - Its handshake lands in the GAP cycle, in the same cycle as requester 0's `resp_valid`.
- **Timeout:** the bench model withholds `mult_done`.
  - `err` = 1 after 4 BUSY cycles, then GAP with `resp_valid` = 0.
  - `err` stays set until `reset`.
- **Reset mid-op:** assert `reset` in BUSY cycle 2.
  - Next cycle: IDLE, `mult_go` = 0, no `resp_valid`.
  - The next simultaneous request from both requesters grants requester 0.

Source files
------------

// File: rtl/fp_mult_rr_sched.sv
// fp_mult_rr_sched: round-robin front end for one shared pipelined multiplier.
// Requesters hand over operand pairs with valid/ready. The chosen pair is held
// on the multiplier while go stays high. After every operation, go drops for
// one cycle so the multiplier's done pipeline drains before the next issue.
module fp_mult_rr_sched #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_left,
  input  logic [NUM_REQ*WIDTH-1:0]   req_right,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       mult_go,
  output logic [WIDTH-1:0]           mult_left,
  output logic [WIDTH-1:0]           mult_right,
  input  logic [WIDTH-1:0]           mult_out,
  input  logic                       mult_done,
  output logic                       err
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] cur_id;
  logic [CNT_W-1:0] busy_cnt;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  int              rr_idx;

  // Round-robin search: the first valid requester at or after last_grant+1, with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    rr_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (!pick_valid && req_valid[rr_idx]) begin
        pick_valid = 1'b1;
        pick_id    = rr_idx[ID_W-1:0];
      end
    end
  end

  // One-hot grant, offered only while arbitration is open (IDLE or GAP).
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && (state != BUSY) && pick_valid && (pick_id == ID_W'(i));
    end
  end

  // Control FSM with registered multiplier go, operand latches and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      busy_cnt   <= '0;
      mult_go    <= 1'b0;
      mult_left  <= '0;
      mult_right <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      err        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (pick_valid) begin
            state      <= BUSY;
            mult_go    <= 1'b1;
            mult_left  <= req_left[pick_id*WIDTH +: WIDTH];
            mult_right <= req_right[pick_id*WIDTH +: WIDTH];
            cur_id     <= pick_id;
            last_grant <= pick_id;
            busy_cnt   <= '0;
          end else begin
            state   <= IDLE;
            mult_go <= 1'b0;
          end
        end
        BUSY: begin
          if (mult_done) begin
            resp_data  <= mult_out;
            resp_id    <= cur_id;
            resp_valid <= 1'b1;
            state      <= GAP;
            mult_go    <= 1'b0;
          end else if (busy_cnt == CNT_W'(LATENCY - 1)) begin
            // Multiplier missed its slot: flag it and drop the op without a response.
            err     <= 1'b1;
            state   <= GAP;
            mult_go <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mult_go <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_rr_sched.sv
// Bench for fp_mult_rr_sched: a behavioural 4-cycle multiplier model, a response
// scoreboard fed with expected products, a vector table and hand-written
// sequences for timing, fairness, back-to-back issue, timeout and reset.
module tb_fp_mult_rr_sched;
  localparam int WIDTH = 4, NUM_REQ = 2, ID_W = 3, LATENCY = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_left, req_right;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_data;
  logic                     mult_go;
  logic [WIDTH-1:0]         mult_left, mult_right, mult_out;
  logic                     mult_done;
  logic                     err;

  fp_mult_rr_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_left(req_left),
    .req_right(req_right), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .mult_go(mult_go),
    .mult_left(mult_left), .mult_right(mult_right), .mult_out(mult_out),
    .mult_done(mult_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done in the 4th consecutive go-high cycle; can be withheld.
  logic       withhold = 1'b0;
  logic [2:0] go_cnt = 3'd0;
  always @(posedge clk) begin
    if (reset || !mult_go) go_cnt <= 3'd0;
    else if (go_cnt != 3'd7) go_cnt <= go_cnt + 3'd1;
  end
  assign mult_done = !withhold && mult_go && (go_cnt == 3'd3);

  function automatic logic [3:0] model_mul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb, p;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    p  = sa * sb;
    return p[3:0];
  endfunction
  assign mult_out = model_mul(mult_left, mult_right);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [3:0]      data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [3:0]      l;
    logic [3:0]      r;
    logic [3:0]      exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int id, input logic [3:0] d);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Response monitor: every resp_valid must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL ready_onehot actual=%b required=at most one bit", req_ready);
      end
      if (resp_valid) begin
        chk("gap_go_low", 32'(mult_go), 0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual id=%0d data=%h required=no response", resp_id, resp_data);
        end else begin
          e = sb_q.pop_front();
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_data", 32'(resp_data), 32'(e.data));
          $display("resp id=%0d data=%h (expected id=%0d data=%h)", resp_id, resp_data, e.id, e.data);
        end
      end
    end
  end

  // Drive one requester and wait (bounded) for its handshake; ends in the cycle after it.
  task automatic issue(input int id, input logic [3:0] l, input logic [3:0] r,
                       input bit push, input logic [3:0] exp, output int t_hs);
    bit got;
    got = 1'b0;
    t_hs = -1;
    req_left[id*WIDTH +: WIDTH]  = l;
    req_right[id*WIDTH +: WIDTH] = r;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        t_hs = cyc;
        if (push) push_exp(id, exp);
        $display("issue id=%0d %h x %h at cycle %0d", id, l, r, cyc);
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_timeout actual=no grant required=grant for id %0d", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been seen.
  task automatic drain();
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1, hs, prev, exp_id;
    bit found;

    vecs[0] = '{3'd0, 4'hE, 4'h3, 4'hA};
    vecs[1] = '{3'd0, 4'h7, 4'h7, 4'h1};
    vecs[2] = '{3'd0, 4'h8, 4'hF, 4'h8};
    vecs[3] = '{3'd1, 4'h5, 4'h3, 4'hF};
    vecs[4] = '{3'd1, 4'h4, 4'h4, 4'h0};
    vecs[5] = '{3'd1, 4'hF, 4'hF, 4'h1};
    vecs[6] = '{3'd0, 4'hF, 4'h1, 4'hF};
    vecs[7] = '{3'd1, 4'h6, 4'h5, 4'hE};

    // Reset state, with both requesters already asking.
    reset = 1'b1;
    req_valid = 2'b11;
    req_left = '0;
    req_right = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_go", 32'(mult_go), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_left", 32'(mult_left), 0);
    chk("rst_right", 32'(mult_right), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 2'b00;

    // Single op with exact timing: 3 x 2.
    req_left[0 +: 4] = 4'h3;
    req_right[0 +: 4] = 4'h2;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("single_ready_T", 32'(req_ready), 1);
    push_exp(0, 4'h6);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 2'b00;
      @(negedge clk);
      if (k < 5) begin
        chk("single_go_busy", 32'(mult_go), 1);
      end else begin
        chk("single_go_gap", 32'(mult_go), 0);
        chk("single_resp_valid_T5", 32'(resp_valid), 1);
      end
    end
    @(posedge clk); #1;
    drain();

    // Table of operand pairs, including signed wrap cases.
    for (int i = 0; i < 8; i++) begin
      issue(int'(vecs[i].id), vecs[i].l, vecs[i].r, 1'b1, vecs[i].exp, t0);
      drain();
    end

    // Back-to-back: requester 1 arrives while requester 0 is busy.
    issue(0, 4'h2, 4'h2, 1'b1, 4'h4, t0);
    req_left[4 +: 4] = 4'h1;
    req_right[4 +: 4] = 4'hF;
    req_valid[1] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        found = 1'b1;
        chk("b2b_resp_same_cycle", 32'(resp_valid), 1);
        chk("b2b_spacing", 32'(cyc - t0), 5);
        push_exp(1, 4'hF);
        $display("issue id=1 1 x f at cycle %0d (GAP)", cyc);
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_granted", 32'(found), 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Timeout: multiplier never reports done.
    withhold = 1'b1;
    issue(0, 4'h1, 4'h1, 1'b0, 4'h0, t0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("to_go_busy", 32'(mult_go), 1);
      chk("to_err_early", 32'(err), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_err_set", 32'(err), 1);
    chk("to_no_resp", 32'(resp_valid), 0);
    chk("to_go_gap", 32'(mult_go), 0);
    $display("timeout err=%0d resp_valid=%0d", err, resp_valid);
    withhold = 1'b0;
    @(posedge clk); #1;
    issue(1, 4'h2, 4'h3, 1'b1, 4'h6, t0);
    drain();
    @(negedge clk);
    chk("to_err_sticky", 32'(err), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", 32'(err), 0);
    @(posedge clk); #1;

    // Fairness: both requesters hold valid; grants alternate 5 cycles apart.
    req_left = {4'h2, 4'h3};
    req_right = {4'hD, 4'h3};
    req_valid = 2'b11;
    hs = 0;
    prev = -1;
    exp_id = 0;
    for (int c = 0; c < 40; c++) begin
      if (hs == 4) break;
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("fair_grant", 32'(req_ready), (exp_id == 0) ? 1 : 2);
        if (prev >= 0) begin
          chk("fair_spacing", 32'(cyc - prev), 5);
          chk("fair_gap_go", 32'(mult_go), 0);
        end
        $display("fair grant ready=%b at cycle %0d", req_ready, cyc);
        prev = cyc;
        push_exp(exp_id, (exp_id == 0) ? 4'h9 : 4'hA);
        exp_id = exp_id ^ 1;
        hs++;
      end
      @(posedge clk); #1;
      if (hs == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    chk("fair_handshakes", 32'(hs), 4);
    drain();

    // Reset in BUSY cycle 2: op dropped, arbitration restarts at requester 0.
    issue(1, 4'h3, 4'h3, 1'b0, 4'h0, t0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    req_left = {4'h2, 4'h5};
    req_right = {4'h2, 4'h1};
    req_valid = 2'b11;
    @(negedge clk);
    chk("rmid_go", 32'(mult_go), 0);
    chk("rmid_no_resp", 32'(resp_valid), 0);
    chk("rmid_grant0", 32'(req_ready), 1);
    t1 = cyc;
    $display("reset mid-op: grant ready=%b at cycle %0d", req_ready, t1);
    push_exp(0, 4'h5);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
